// File: rtl/mac_tap_sequencer_if.sv
// Bus bundle between mac_tap_sequencer, its weight/activation buffers, the MAC and the output writer.
interface mac_tap_sequencer_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              start;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] x_base;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] x_addr;
   logic [7:0]        w_data;
   logic [7:0]        x_data;
   logic              mem_stall;
   logic              mac_clear;
   logic              mac_active;
   logic [7:0]        mac_val1;
   logic [7:0]        mac_val2;
   logic [7:0]        mac_val_out;
   logic              busy;
   logic [7:0]        result;
   logic              result_valid;
   logic              result_ready;

   modport master (
      input  start, w_base, x_base, w_data, x_data, mem_stall, mac_val_out, result_ready,
      output w_addr, x_addr, mac_clear, mac_active, mac_val1, mac_val2, busy, result,
             result_valid
   );

   modport slave (
      output start, w_base, x_base, w_data, x_data, mem_stall, mac_val_out, result_ready,
      input  w_addr, x_addr, mac_clear, mac_active, mac_val1, mac_val2, busy, result,
             result_valid
   );
endinterface

// File: rtl/mac_tap_sequencer.sv
// Streams TAPS weight/activation pairs from two sync-read buffers into the MAC, then holds its output.
// Build option: define MAC_SEQ_STALL_EN to let mem_stall freeze the tap walk during RUN.
module mac_tap_sequencer #(
   parameter int unsigned TAPS   = 9,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   mac_tap_sequencer_if.master bus
);
   localparam int unsigned      DATA_W   = 8;
   localparam int unsigned      CNT_W    = $clog2(TAPS + 1);
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  tap_q, tap_d;
   logic [ADDR_W-1:0] w_base_q, w_base_d;
   logic [ADDR_W-1:0] x_base_q, x_base_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [ADDR_W-1:0] x_addr_q, x_addr_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              mac_clear_q;
   logic              run_q;
   logic              busy_q;
   logic              result_valid_q;
   logic              stall_c;

`ifdef MAC_SEQ_STALL_EN
   assign stall_c = bus.mem_stall & run_q;
`else
   logic stall_unused;
   assign stall_unused = bus.mem_stall;
   assign stall_c      = 1'b0;
`endif

   // Next state; addresses run one tap ahead because buffer data lags the address by a cycle.
   always_comb begin
      state_d  = state_q;
      tap_d    = tap_q;
      w_base_d = w_base_q;
      x_base_d = x_base_q;
      w_addr_d = w_addr_q;
      x_addr_d = x_addr_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               w_base_d = bus.w_base;
               x_base_d = bus.x_base;
               w_addr_d = bus.w_base;
               x_addr_d = bus.x_base;
               tap_d    = '0;
               state_d  = CLEAR;
            end
         end
         CLEAR: begin
            tap_d    = '0;
            w_addr_d = w_base_q + ADDR_W'(1);
            x_addr_d = x_base_q + ADDR_W'(1);
            state_d  = RUN;
         end
         RUN: begin
            if (!stall_c) begin
               if (tap_q == LAST_TAP) begin
                  state_d = CAPTURE;
               end else begin
                  tap_d    = tap_q + CNT_W'(1);
                  w_addr_d = w_addr_q + ADDR_W'(1);
                  x_addr_d = x_addr_q + ADDR_W'(1);
               end
            end
         end
         CAPTURE: begin
            result_d = bus.mac_val_out;
            state_d  = HOLD;
         end
         HOLD: begin
            if (bus.result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, decoded from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         tap_q          <= '0;
         w_base_q       <= '0;
         x_base_q       <= '0;
         w_addr_q       <= '0;
         x_addr_q       <= '0;
         result_q       <= '0;
         mac_clear_q    <= 1'b0;
         run_q          <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         tap_q          <= tap_d;
         w_base_q       <= w_base_d;
         x_base_q       <= x_base_d;
         w_addr_q       <= w_addr_d;
         x_addr_q       <= x_addr_d;
         result_q       <= result_d;
         mac_clear_q    <= (state_d == CLEAR);
         run_q          <= (state_d == RUN);
         busy_q         <= (state_d != IDLE);
         result_valid_q <= (state_d == HOLD);
      end
   end

   // Operands pass straight through so the MAC sees buffer data in the cycle it arrives.
   assign bus.w_addr       = w_addr_q;
   assign bus.x_addr       = x_addr_q;
   assign bus.mac_clear    = mac_clear_q;
   assign bus.mac_active   = run_q & ~stall_c;
   assign bus.mac_val1     = run_q ? bus.w_data : '0;
   assign bus.mac_val2     = run_q ? bus.x_data : '0;
   assign bus.busy         = busy_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Bench for mac_tap_sequencer: TAPS=3 and TAPS=9 instances with buffer and MAC models.
module tb_mac_tap_sequencer;
   localparam int T3 = 3;
`ifdef MAC_SEQ_STALL_EN
   localparam int STALL_EXTRA = 2;
`else
   localparam int STALL_EXTRA = 0;
`endif

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] wmem [16];
   logic [7:0] xmem [16];
   logic [7:0] junk;

   mac_tap_sequencer_if #(.ADDR_W(4)) b3 ();
   mac_tap_sequencer_if #(.ADDR_W(4)) b9 ();

   mac_tap_sequencer #(.TAPS(3), .ADDR_W(4)) dut3 (.clk(clk), .rst(rst), .bus(b3));
   mac_tap_sequencer #(.TAPS(9), .ADDR_W(4)) dut9 (.clk(clk), .rst(rst), .bus(b9));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) junk <= 8'($urandom);

   // Buffer models: sync read; a stalled buffer keeps its read register and shows garbage.
   logic       stall3;
   logic [7:0] w_rd3, x_rd3, w_rd9, x_rd9;
`ifdef MAC_SEQ_STALL_EN
   assign stall3 = b3.mem_stall;
`else
   assign stall3 = 1'b0;
`endif
   always @(posedge clk) begin
      if (!stall3) begin
         w_rd3 <= wmem[b3.w_addr];
         x_rd3 <= xmem[b3.x_addr];
      end
      w_rd9 <= wmem[b9.w_addr];
      x_rd9 <= xmem[b9.x_addr];
   end
   assign b3.w_data = stall3 ? junk : w_rd3;
   assign b3.x_data = stall3 ? ~junk : x_rd3;
   assign b9.w_data = w_rd9;
   assign b9.x_data = x_rd9;

   // MAC models: 12-bit accumulator of product[15:8], output is acc[11:4].
   logic [15:0] prod3, prod9;
   logic [11:0] acc3, acc9;
   assign prod3 = 16'(b3.mac_val1) * 16'(b3.mac_val2);
   assign prod9 = 16'(b9.mac_val1) * 16'(b9.mac_val2);
   always @(posedge clk) begin
      if (rst || b3.mac_clear) acc3 <= '0;
      else if (b3.mac_active)  acc3 <= acc3 + 12'(prod3[15:8]);
      if (rst || b9.mac_clear) acc9 <= '0;
      else if (b9.mac_active)  acc9 <= acc9 + 12'(prod9[15:8]);
   end
   assign b3.mac_val_out = acc3[11:4];
   assign b9.mac_val_out = acc9[11:4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("clear_active_exclusive", 32'(b3.mac_clear & b3.mac_active), 32'd0);
         chk("clear_active_exclusive9", 32'(b9.mac_clear & b9.mac_active), 32'd0);
      end
   end

   // Reference: sum of (w*x)>>8 over the taps, kept to 12 bits, top 8 bits reported.
   function automatic logic [7:0] ref_result(input logic [3:0] wb, input logic [3:0] xb,
                                             input int taps);
      int sum;
      sum = 0;
      for (int k = 0; k < taps; k++)
         sum += (int'(wmem[4'(wb + k)]) * int'(xmem[4'(xb + k)])) / 256;
      return 8'((sum % 4096) / 16);
   endfunction

   task automatic fill_const(input logic [7:0] wv, input logic [7:0] xv);
      for (int i = 0; i < 16; i++) begin
         wmem[i] = wv;
         xmem[i] = xv;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 16; i++) begin
         wmem[i] = 8'($urandom);
         xmem[i] = 8'($urandom);
      end
   endtask

   // One full transaction on the TAPS=3 instance, starting from IDLE just after an edge.
   task automatic run_txn(input logic [3:0] wb, input logic [3:0] xb, input logic [7:0] exp_res,
                          input int exp_lat, input int stall_at, input int stall_len,
                          input int hold_cycles);
      int         n, act_cnt, clr_cnt;
      logic [3:0] pw, px;
      logic       stall_now, prev_stall;
      b3.w_base       = wb;
      b3.x_base       = xb;
      b3.start        = 1'b1;
      b3.result_ready = (hold_cycles == 0);
      @(posedge clk); #1;
      b3.start   = 1'b0;
      n          = 0;
      act_cnt    = 0;
      clr_cnt    = 0;
      pw         = '0;
      px         = '0;
      prev_stall = 1'b0;
      while (n < 60) begin
         stall_now    = (n >= stall_at) && (n < stall_at + stall_len);
         b3.mem_stall = stall_now;
         #1;
         if (b3.result_valid) break;
         if (b3.mac_clear) begin
            clr_cnt++;
            chk("clear_w_addr", 32'(b3.w_addr), 32'(wb));
            chk("clear_x_addr", 32'(b3.x_addr), 32'(xb));
         end
         if (b3.mac_active) begin
            if (act_cnt < T3 - 1) begin
               chk("tap_w_addr", 32'(b3.w_addr), 32'(4'(wb + act_cnt + 1)));
               chk("tap_x_addr", 32'(b3.x_addr), 32'(4'(xb + act_cnt + 1)));
            end
            act_cnt++;
         end
`ifdef MAC_SEQ_STALL_EN
         if (stall_now) chk("stall_active_low", 32'(b3.mac_active), 32'd0);
         if (prev_stall) begin
            chk("stall_w_addr_held", 32'(b3.w_addr), 32'(pw));
            chk("stall_x_addr_held", 32'(b3.x_addr), 32'(px));
         end
`endif
         prev_stall = stall_now;
         pw         = b3.w_addr;
         px         = b3.x_addr;
         @(posedge clk); #1;
         n++;
      end
      b3.mem_stall = 1'b0;
      chk("start_to_valid_latency", 32'(n), 32'(exp_lat));
      chk("result", 32'(b3.result), 32'(exp_res));
      chk("active_cycles", 32'(act_cnt), 32'(T3));
      chk("clear_pulses", 32'(clr_cnt), 32'd1);
      for (int i = 0; i < hold_cycles; i++) begin
         b3.start  = i[0];
         b3.w_base = 4'($urandom);
         @(posedge clk); #1;
         b3.start = 1'b0;
         chk("hold_valid", 32'(b3.result_valid), 32'd1);
         chk("hold_result", 32'(b3.result), 32'(exp_res));
         chk("hold_busy", 32'(b3.busy), 32'd1);
      end
      // Handshake edge with start also high: the start must be ignored.
      b3.result_ready = 1'b1;
      b3.start        = 1'b1;
      @(posedge clk); #1;
      b3.start = 1'b0;
      chk("valid_after_accept", 32'(b3.result_valid), 32'd0);
      chk("handshake_start_ignored", 32'(b3.busy), 32'd0);
      chk("result_kept", 32'(b3.result), 32'(exp_res));
   endtask

   typedef struct {
      logic [3:0] wb;
      logic [3:0] xb;
      logic [7:0] wv;
      logic [7:0] xv;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int         n9, act9;
      logic [3:0] rwb, rxb;
      vecs[0] = '{4'h0, 4'h0, 8'h80, 8'h20, 8'h03};
      vecs[1] = '{4'hE, 4'h3, 8'hFF, 8'hFF, 8'h2F};
      vecs[2] = '{4'h5, 4'hA, 8'h10, 8'h10, 8'h00};
      vecs[3] = '{4'h7, 4'h9, 8'hC0, 8'hC0, 8'h1B};
      vecs[4] = '{4'hF, 4'hF, 8'h00, 8'hFF, 8'h00};
      vecs[5] = '{4'h3, 4'hC, 8'h80, 8'hFF, 8'h17};

      fill_const(8'h00, 8'h00);
      b3.start = 1'b0; b3.w_base = '0; b3.x_base = '0; b3.mem_stall = 1'b0; b3.result_ready = 1'b0;
      b9.start = 1'b0; b9.w_base = '0; b9.x_base = '0; b9.mem_stall = 1'b0; b9.result_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(b3.busy), 32'd0);
      chk("rst_w_addr", 32'(b3.w_addr), 32'd0);
      chk("rst_x_addr", 32'(b3.x_addr), 32'd0);
      chk("rst_mac_clear", 32'(b3.mac_clear), 32'd0);
      chk("rst_mac_active", 32'(b3.mac_active), 32'd0);
      chk("rst_mac_val1", 32'(b3.mac_val1), 32'd0);
      chk("rst_result", 32'(b3.result), 32'd0);
      chk("rst_result_valid", 32'(b3.result_valid), 32'd0);
      chk("rst_busy9", 32'(b9.busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed constant-operand vectors, back to back at the minimum interval.
      for (int v = 0; v < 6; v++) begin
         fill_const(vecs[v].wv, vecs[v].xv);
         run_txn(vecs[v].wb, vecs[v].xb, vecs[v].exp, T3 + 2, 99, 0, 0);
      end

      // Random buffer contents and bases against the arithmetic reference.
      for (int r = 0; r < 20; r++) begin
         fill_rand();
         rwb = 4'($urandom);
         rxb = 4'($urandom);
         run_txn(rwb, rxb, ref_result(rwb, rxb, T3), T3 + 2, 99, 0, int'($urandom_range(0, 3)));
      end

      // Address wrap, then reset in the second RUN cycle.
      for (int i = 0; i < 16; i++) begin
         wmem[i] = 8'(i * 16 + 1);
         xmem[i] = 8'(255 - i);
      end
      b3.w_base = 4'hE;
      b3.x_base = 4'h1;
      b3.start  = 1'b1;
      @(posedge clk); #1;
      b3.start = 1'b0;
      chk("wrap_clear", 32'(b3.mac_clear), 32'd1);
      chk("wrap_addr0", 32'(b3.w_addr), 32'hE);
      @(posedge clk); #1;
      chk("wrap_addr1", 32'(b3.w_addr), 32'hF);
      chk("wrap_active0", 32'(b3.mac_active), 32'd1);
      @(posedge clk); #1;
      chk("wrap_addr2", 32'(b3.w_addr), 32'h0);
      chk("wrap_x_addr2", 32'(b3.x_addr), 32'h3);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 32'(b3.busy), 32'd0);
      chk("abort_w_addr", 32'(b3.w_addr), 32'd0);
      chk("abort_x_addr", 32'(b3.x_addr), 32'd0);
      chk("abort_active", 32'(b3.mac_active), 32'd0);
      chk("abort_clear", 32'(b3.mac_clear), 32'd0);
      chk("abort_val2", 32'(b3.mac_val2), 32'd0);
      chk("abort_result", 32'(b3.result), 32'd0);
      chk("abort_valid", 32'(b3.result_valid), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("abort_quiet", {29'd0, b3.result_valid, b3.mac_clear, b3.busy}, 32'd0);
      end

      // Stalled handshake for 10 cycles with start pulses, then a fresh start.
      fill_rand();
      run_txn(4'h9, 4'h2, ref_result(4'h9, 4'h2, T3), T3 + 2, 99, 0, 10);
      run_txn(4'h4, 4'hB, ref_result(4'h4, 4'hB, T3), T3 + 2, 99, 0, 0);

      // Buffer stall for two cycles during tap 1.
      fill_rand();
      run_txn(4'hD, 4'h6, ref_result(4'hD, 4'h6, T3), T3 + 2 + STALL_EXTRA, 2, 2, 0);

      // TAPS=9 with all operands 8'hFF: 9 * 8'hFE = 12'h8EE.
      fill_const(8'hFF, 8'hFF);
      b9.w_base       = 4'h9;
      b9.x_base       = 4'h3;
      b9.result_ready = 1'b1;
      b9.start        = 1'b1;
      @(posedge clk); #1;
      b9.start = 1'b0;
      n9   = 0;
      act9 = 0;
      while (n9 < 60 && !b9.result_valid) begin
         if (b9.mac_clear) begin
            chk("t9_clear_w_addr", 32'(b9.w_addr), 32'h9);
            chk("t9_clear_x_addr", 32'(b9.x_addr), 32'h3);
         end
         if (b9.mac_active) begin
            if (act9 < 8) begin
               chk("t9_w_addr", 32'(b9.w_addr), 32'(4'(4'h9 + act9 + 1)));
               chk("t9_x_addr", 32'(b9.x_addr), 32'(4'(4'h3 + act9 + 1)));
            end
            act9++;
         end
         @(posedge clk); #1;
         n9++;
      end
      chk("t9_latency", 32'(n9), 32'd11);
      chk("t9_result", 32'(b9.result), 32'h8E);
      chk("t9_active_cycles", 32'(act9), 32'd9);
      @(posedge clk); #1;
      chk("t9_valid_pulse", 32'(b9.result_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mac_tap_sequencer.md
# mac_tap_sequencer

Upstream sequencer for the 8-bit MAC accumulator in the convolution datapath. Given a start pulse and two base addresses, it reads TAPS weight/activation pairs from two synchronous-read buffers, streams them into the MAC with the correct clear/active timing, and captures the MAC's 8-bit output. It then holds the captured value behind a valid/ready handshake for the output writer.

## Interface
- TAPS, 9, number of weight/activation pairs accumulated per result (1..16)
- ADDR_W, 4, buffer address width; addresses wrap modulo 2^ADDR_W

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  start request, sampled only in IDLE
- w_base, x_base  in  ADDR_W  base addresses, latched on accepted start
- w_addr, x_addr  out  ADDR_W  buffer read addresses; data returns one cycle later
- w_data, x_data  in  8  buffer read data
- mem_stall  in  1  buffer not ready this cycle (see Configuration)
- mac_clear, mac_active  out  1  to MAC clear/active
- mac_val1, mac_val2  out  8  to MAC operands (weight, activation)
- mac_val_out  in  8  from MAC output
- busy  out  1  high in every state except IDLE
- result  out  8  captured MAC output
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE, HOLD.
- IDLE: if start=1, latch w_base/x_base and go to CLEAR; otherwise stay in IDLE.
- CLEAR (1 cycle): mac_clear=1; w_addr/x_addr = base+0; tap counter=0; go to RUN.
- RUN, tap k: mac_val1=w_data, mac_val2=x_data, mac_active=1; addresses = base+k+1, which are don't-care on the last tap. After tap TAPS-1, go to CAPTURE.
- CAPTURE (1 cycle): result <= mac_val_out; go to HOLD.
- HOLD: result_valid=1. If result_ready=1, go to IDLE; result keeps its value until the next capture.
- Outside RUN: mac_val1/mac_val2 = 0 and mac_active = 0. mac_clear and mac_active are never high together.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is legal and silent.
- Tap counter width is ceil(log2(TAPS+1)). TAPS=1 gives exactly one RUN cycle.
- start while busy=1 is ignored, including in HOLD during the handshake cycle. A new start is accepted only in a cycle where the state is IDLE.

## Timing
- Reset values: state IDLE; all outputs 0 (addresses 0, result 0, result_valid 0, busy 0).
- Reset in any state aborts the operation in the next cycle with no clear pulse. The MAC is reset by the same rst.
- Latency without stalls:
  - start sampled at edge E0: CLEAR after E0; RUN taps after E1..E_TAPS; CAPTURE after E_TAPS+1; result_valid=1 after E_TAPS+2.
  - Start-to-valid is TAPS+2 cycles.
- result_valid stays high until the first edge with result_ready=1. With result_ready held high it is high for exactly one cycle.
- Minimum start-to-start interval is TAPS+4 cycles.

## Configuration
- MAC_SEQ_STALL_EN defined:
  - In RUN, mem_stall=1 forces mac_active=0 and freezes the addresses and tap counter for that cycle.
  - Buffer data is assumed valid again on the first cycle with mem_stall=0 at the held address.
  - Each stall cycle adds one cycle of latency.
  - mem_stall is ignored outside RUN.
- MAC_SEQ_STALL_EN undefined: mem_stall is present but ignored; timing is exactly as specified above.

## Test plan
- TAPS=3, every w=8'h80, every x=8'h20, result_ready=1: result=8'h03; result_valid is a single pulse 5 cycles after the start edge; mac_active high for exactly 3 cycles.
- TAPS=9, all operands 8'hFF: each tap adds 8'hFE, accumulator 12'h8EE, result=8'h8E; w_addr/x_addr step base..base+9.
- w_base=4'hE, TAPS=3: w_addr sequence E, F, 0, 1 (wrap). Reset asserted in the second RUN cycle: next cycle in IDLE, all outputs 0, no result_valid.
- result_ready=0 for 10 cycles after result_valid: result_valid and result stay stable; start pulses during HOLD are ignored. Raising result_ready returns to IDLE, and a new start is then accepted.
- With MAC_SEQ_STALL_EN, TAPS=3, mem_stall=1 for 2 cycles during tap 1: addresses held, mac_active low during the stall, result unchanged versus the unstalled run, latency +2. Without the macro, the same stimulus gives unstalled timing.
